// File: rtl/matrix_result_collector_if.sv
// Stream and read-port bundle between the matrix multiplier, the result collector and the
// downstream Kalman stage. The master drives the stream and read address; the slave collects.
interface matrix_result_collector_if #(
  parameter int unsigned MAX_COL  = 4,
  parameter int unsigned MAX_ROW1 = 4,
  parameter int unsigned DATA_W   = 16
);
  localparam int unsigned DEPTH  = MAX_COL * MAX_ROW1;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned COL_W  = $clog2(MAX_COL) + 1;
  localparam int unsigned ROW1_W = $clog2(MAX_ROW1) + 1;

  logic              start_i;
  logic [COL_W-1:0]  COL;
  logic [ROW1_W-1:0] ROW1;
  logic [DATA_W-1:0] data_i;
  logic              data_i_v;
  logic              cal_finish_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0] rd_data_o;

  modport master (
    output start_i, COL, ROW1, data_i, data_i_v, cal_finish_i, rd_addr_i,
    input  rd_data_o
  );

  modport slave (
    input  start_i, COL, ROW1, data_i, data_i_v, cal_finish_i, rd_addr_i,
    output rd_data_o
  );
endinterface

// File: rtl/matrix_result_collector.sv
// Collects streamed multiplier results into a local buffer and serves a registered read port.
// Define MATRIX_RESULT_TRANSPOSE_EN to store the result transposed (b_idx*COL + c_idx).
module matrix_result_collector #(
  parameter int unsigned MAX_COL  = 4,
  parameter int unsigned MAX_ROW1 = 4,
  parameter int unsigned DATA_W   = 16,
  localparam int unsigned DEPTH   = MAX_COL * MAX_ROW1,
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  matrix_result_collector_if.slave bus,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ADDR_W:0]          count_o,
  output logic                     err_o
);
  localparam int unsigned COL_W  = $clog2(MAX_COL) + 1;
  localparam int unsigned ROW1_W = $clog2(MAX_ROW1) + 1;

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d, c_idx_q, c_idx_d;
  logic [ROW1_W-1:0]   row1_q, row1_d, b_idx_q, b_idx_d;
  logic [ADDR_W:0]     count_q, count_d, total;
  logic                err_q, err_d, busy_q, busy_d, done_q, done_d;
  logic                ran_q, ran_d;
  logic                dims_ok, wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  assign dims_ok = (bus.COL != '0) && (bus.COL <= COL_W'(MAX_COL)) &&
                   (bus.ROW1 != '0) && (bus.ROW1 <= ROW1_W'(MAX_ROW1));
  assign total   = (ADDR_W+1)'(col_q) * (ADDR_W+1)'(row1_q);

`ifdef MATRIX_RESULT_TRANSPOSE_EN
  assign wr_addr = ADDR_W'(b_idx_q) * ADDR_W'(col_q) + ADDR_W'(c_idx_q);
`else
  assign wr_addr = ADDR_W'(c_idx_q) * ADDR_W'(row1_q) + ADDR_W'(b_idx_q);
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row1_d  = row1_q;
    c_idx_d = c_idx_q;
    b_idx_d = b_idx_q;
    count_d = count_q;
    err_d   = err_q;
    ran_d   = ran_q;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          if (dims_ok) begin
            col_d   = bus.COL;
            row1_d  = bus.ROW1;
            c_idx_d = '0;
            b_idx_d = '0;
            count_d = '0;
            err_d   = 1'b0;
            ran_d   = 1'b0;
            state_d = StCollect;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.data_i_v && ran_q) begin
          err_d = 1'b1;  // overrun after a finished run; data dropped
        end
      end
      StCollect: begin
        if (bus.data_i_v) begin
          wr_en   = 1'b1;
          count_d = count_q + 1'b1;
          if (b_idx_q + 1'b1 == row1_q) begin
            b_idx_d = '0;
            c_idx_d = c_idx_q + 1'b1;
          end else begin
            b_idx_d = b_idx_q + 1'b1;
          end
        end
        // A final element arriving with cal_finish_i wins over the early-finish error.
        if (count_d == total) begin
          state_d = StDone;
        end else if (bus.cal_finish_i) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        ran_d   = 1'b1;
        if (bus.data_i_v) err_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_d = (state_d == StCollect);
  assign done_d = (state_q == StDone);

  always_comb begin
    rd_data_d = '0;
    if ({1'b0, bus.rd_addr_i} < (ADDR_W+1)'(DEPTH)) rd_data_d = mem_q[bus.rd_addr_i];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      col_q     <= '0;
      row1_q    <= '0;
      c_idx_q   <= '0;
      b_idx_q   <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      ran_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row1_q    <= row1_d;
      c_idx_q   <= c_idx_d;
      b_idx_q   <= b_idx_d;
      count_q   <= count_d;
      err_q     <= err_d;
      ran_q     <= ran_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Buffer is deliberately not reset so partial results survive a mid-run reset.
  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) mem_q[wr_addr] <= bus.data_i;
  end

  assign bus.rd_data_o = rd_data_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign count_o       = count_q;
  assign err_o         = err_q;
endmodule

// File: tb/tb_matrix_result_collector.sv
// Randomized bench for matrix_result_collector against an element-index reference model.
module tb_matrix_result_collector;
  localparam int unsigned MAX_COL  = 4;
  localparam int unsigned MAX_ROW1 = 4;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned DEPTH    = MAX_COL * MAX_ROW1;
  localparam int unsigned ADDR_W   = $clog2(DEPTH);
  localparam int unsigned COL_W    = $clog2(MAX_COL) + 1;
  localparam int unsigned ROW1_W   = $clog2(MAX_ROW1) + 1;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            busy_o, done_o, err_o;
  logic [ADDR_W:0] count_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] mem_m [DEPTH];
  bit                mv    [DEPTH];
  int                exp6  [6];

  matrix_result_collector_if #(
    .MAX_COL (MAX_COL),
    .MAX_ROW1(MAX_ROW1),
    .DATA_W  (DATA_W)
  ) bus ();

  matrix_result_collector #(
    .MAX_COL (MAX_COL),
    .MAX_ROW1(MAX_ROW1),
    .DATA_W  (DATA_W)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bus    (bus),
    .busy_o (busy_o),
    .done_o (done_o),
    .count_o(count_o),
    .err_o  (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Element k of a run is row k/ROW1, column k%ROW1 of the COL x ROW1 result.
  function automatic int ref_addr(input int k, input int col, input int row1);
    int r, c;
    r = k / row1;
    c = k % row1;
`ifdef MATRIX_RESULT_TRANSPOSE_EN
    return c * col + r;
`else
    return r * row1 + c;
`endif
  endfunction

  task automatic reset_dut();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_count", 32'(count_o), 0);
    check("rst_err", 32'(err_o), 0);
  endtask

  task automatic readback(input string tag);
    for (int a = 0; a < int'(DEPTH); a++) begin
      if (mv[a]) begin
        bus.rd_addr_i = ADDR_W'(a);
        tick();
        check(tag, 32'(bus.rd_data_o), 32'(mem_m[a]));
      end
    end
    bus.rd_addr_i = '0;
  endtask

  task automatic send_elem(input int k, input int col, input int row1, input int gmin,
                           input int gmax, input bit fixed, input bit cal);
    int a, d;
    repeat ($urandom_range(gmax, gmin)) begin
      tick();
      check("busy_in_gap", 32'(busy_o), 1);
      check("no_early_done", 32'(done_o), 0);
    end
    d = fixed ? k + 1 : int'($urandom_range(65535, 0));
    a = ref_addr(k, col, row1);
    bus.data_i       = DATA_W'(d);
    bus.data_i_v     = 1'b1;
    bus.cal_finish_i = cal;
    tick();
    bus.data_i_v     = 1'b0;
    bus.cal_finish_i = 1'b0;
    if (k == 0 && mv[0]) check("rw_same_addr_old", 32'(bus.rd_data_o), 32'(mem_m[0]));
    mem_m[a] = DATA_W'(d);
    mv[a]    = 1'b1;
    check("count", 32'(count_o), k + 1);
  endtask

  task automatic start_run(input int col, input int row1);
    bus.rd_addr_i = '0;
    bus.COL       = COL_W'(col);
    bus.ROW1      = ROW1_W'(row1);
    bus.start_i   = 1'b1;
    tick();
    bus.start_i   = 1'b0;
  endtask

  task automatic do_run(input int col, input int row1, input int n, input int gmin,
                        input int gmax, input bit fixed, input bit cal_last);
    int total;
    bit exp_err;
    total = col * row1;
    start_run(col, row1);
    check("start_busy", 32'(busy_o), 1);
    check("start_err_clear", 32'(err_o), 0);
    check("start_count", 32'(count_o), 0);
    for (int k = 0; k < n; k++)
      send_elem(k, col, row1, gmin, gmax, fixed, (k == n - 1) && (n == total) && cal_last);
    exp_err = (n < total);
    if (n < total) begin
      repeat ($urandom_range(2, 0)) tick();
      bus.cal_finish_i = 1'b1;
      tick();
      bus.cal_finish_i = 1'b0;
    end
    check("end_busy", 32'(busy_o), 0);
    check("end_no_done_yet", 32'(done_o), 0);
    if (n == total && !cal_last) bus.cal_finish_i = 1'b1;
    tick();
    bus.cal_finish_i = 1'b0;
    check("done_pulse", 32'(done_o), 1);
    check("final_count", 32'(count_o), n);
    check("final_err", 32'(err_o), 32'(exp_err));
    tick();
    check("done_single", 32'(done_o), 0);
    check("idle_busy", 32'(busy_o), 0);
  endtask

  task automatic stray_valid();
    bus.data_i   = DATA_W'($urandom_range(65535, 0));
    bus.data_i_v = 1'b1;
    tick();
    bus.data_i_v = 1'b0;
    check("overrun_err", 32'(err_o), 1);
    check("overrun_busy", 32'(busy_o), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int col, row1, total;
    logic [DATA_W-1:0] saved3;
`ifdef MATRIX_RESULT_TRANSPOSE_EN
    exp6 = '{1, 4, 2, 5, 3, 6};
`else
    exp6 = '{1, 2, 3, 4, 5, 6};
`endif
    rst_i            = 1'b1;
    bus.start_i      = 1'b0;
    bus.COL          = '0;
    bus.ROW1         = '0;
    bus.data_i       = '0;
    bus.data_i_v     = 1'b0;
    bus.cal_finish_i = 1'b0;
    bus.rd_addr_i    = '0;
    for (int a = 0; a < int'(DEPTH); a++) mv[a] = 1'b0;
    reset_dut();
    check("rst_rd_data", 32'(bus.rd_data_o), 0);

    // 2x3 run, values 1..6 three cycles apart, cal_finish after.
    do_run(2, 3, 6, 2, 2, 1'b1, 1'b0);
    for (int a = 0; a < 6; a++) begin
      bus.rd_addr_i = ADDR_W'(a);
      tick();
      check("run1_value", 32'(bus.rd_data_o), exp6[a]);
    end
    stray_valid();
    readback("overrun_unchanged");

    // Full 2x2 then a short 3-element run.
    do_run(2, 2, 4, 0, 2, 1'b0, 1'b1);
    saved3 = mem_m[3];
    do_run(2, 2, 3, 0, 2, 1'b0, 1'b0);
    bus.rd_addr_i = ADDR_W'(3);
    tick();
    check("short_addr3_kept", 32'(bus.rd_data_o), 32'(saved3));
    readback("short_readback");

    // Illegal dimensions.
    reset_dut();
    start_run(0, 2);
    check("bad_col0_err", 32'(err_o), 1);
    check("bad_col0_busy", 32'(busy_o), 0);
    reset_dut();
    start_run(2, MAX_ROW1 + 1);
    check("bad_row1_err", 32'(err_o), 1);
    check("bad_row1_busy", 32'(busy_o), 0);
    tick();
    check("bad_row1_busy_later", 32'(busy_o), 0);
    start_run(MAX_COL + 1, 1);
    check("bad_colmax_err", 32'(err_o), 1);
    check("bad_colmax_busy", 32'(busy_o), 0);
    do_run(MAX_COL, MAX_ROW1, MAX_COL * MAX_ROW1, 0, 1, 1'b0, 1'b1);
    readback("full_readback");

    // Reset after 2 of 4 elements.
    start_run(2, 2);
    send_elem(0, 2, 2, 0, 1, 1'b0, 1'b0);
    send_elem(1, 2, 2, 0, 1, 1'b0, 1'b0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midrst_busy", 32'(busy_o), 0);
    check("midrst_count", 32'(count_o), 0);
    repeat (3) begin
      tick();
      check("midrst_no_done", 32'(done_o), 0);
    end
    readback("midrst_readback");

    for (int r = 0; r < 25; r++) begin
      col   = int'($urandom_range(MAX_COL, 1));
      row1  = int'($urandom_range(MAX_ROW1, 1));
      total = col * row1;
      if ($urandom_range(3, 0) == 0) begin
        do_run(col, row1, int'($urandom_range(total - 1, 0)), 0, 2, 1'b0, 1'b0);
      end else begin
        do_run(col, row1, total, 0, 3, 1'b0, 1'($urandom_range(1, 0)));
        if ($urandom_range(3, 0) == 0) stray_valid();
      end
      readback("rand_readback");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
